// File: rtl/seg_scan_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Brief    : Shadow-register write port and commit strobe for seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;

    modport master (output wr_valid, wr_addr, wr_data, commit, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, commit, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-segment scanner with double-buffered digit values.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int GUARD = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            en,
    input  wire logic [NDIG-1:0] mask,
    seg_scan_ctrl_if.slave       wr,
    output logic [6:0]           seg,
    output logic [NDIG-1:0]      an,
    output logic                 frame_done
);

    localparam int            c_cmax       = (DIV > GUARD) ? DIV : GUARD;
    localparam int            c_cw         = $clog2(c_cmax + 1);
    localparam logic [c_cw-1:0] c_div_last   = c_cw'(DIV - 1);
    localparam logic [c_cw-1:0] c_guard_last = c_cw'(GUARD - 1);
    localparam logic [2:0]    c_idx_last   = 3'(NDIG - 1);
    localparam logic [6:0]    c_blank      = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic            r_pending;
    logic [3:0]      r_shadow [NDIG];
    logic [3:0]      r_active [NDIG];

    logic [3:0]      w_cur_nib;
    logic            w_cur_on;
    logic [NDIG-1:0] w_an_sel;
    logic            w_drive_end;
    logic            w_guard_end;
    logic            w_adv;
    logic            w_wrap;
    logic            w_copy;
    logic            w_wr_fire;
    logic [2:0]      w_idx_next;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0: f_decode = 7'h01;
            4'h1: f_decode = 7'h4F;
            4'h2: f_decode = 7'h12;
            4'h3: f_decode = 7'h06;
            4'h4: f_decode = 7'h4C;
            4'h5: f_decode = 7'h24;
            4'h6: f_decode = 7'h20;
            4'h7: f_decode = 7'h0F;
            4'h8: f_decode = 7'h00;
            4'h9: f_decode = 7'h04;
            4'hA: f_decode = 7'h08;
            4'hB: f_decode = 7'h60;
            4'hC: f_decode = 7'h31;
            4'hD: f_decode = 7'h42;
            4'hE: f_decode = 7'h30;
            default: f_decode = 7'h38;
        endcase
    endfunction

    // Digit select by comparison keeps every index inside the NDIG-entry arrays.
    always_comb begin
        w_cur_nib = 4'h0;
        w_cur_on  = 1'b0;
        w_an_sel  = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == 3'(i)) begin
                w_cur_nib   = r_active[i];
                w_cur_on    = mask[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    assign w_drive_end = (r_state == ST_DRIVE) && (r_cnt == c_div_last);
    assign w_guard_end = (r_state == ST_GUARD) && (r_cnt == c_guard_last);
    assign w_adv       = (GUARD == 0) ? w_drive_end : w_guard_end;
    assign w_wrap      = en && w_adv && (r_idx == c_idx_last);
    assign w_idx_next  = (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
    assign w_wr_fire   = wr.wr_valid && !r_pending;
    // OFF copies unconditionally; while scanning the frame wrap is the only copy point.
    assign w_copy      = r_pending && ((r_state == ST_OFF) || w_wrap);
    assign wr.wr_ready = ~r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            seg        <= c_blank;
            an         <= '1;
            frame_done <= 1'b0;
        end else if (!en) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            seg        <= c_blank;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_wrap;
            if ((r_state == ST_DRIVE) && w_cur_on) begin
                seg <= f_decode(w_cur_nib);
                an  <= w_an_sel;
            end else begin
                seg <= c_blank;
                an  <= '1;
            end
            case (r_state)
                ST_OFF: begin
                    r_state <= ST_DRIVE;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                end
                ST_DRIVE: begin
                    if (w_drive_end) begin
                        r_cnt <= '0;
                        if (GUARD == 0) begin
                            r_idx <= w_idx_next;
                        end else begin
                            r_state <= ST_GUARD;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                ST_GUARD: begin
                    if (w_guard_end) begin
                        r_state <= ST_DRIVE;
                        r_cnt   <= '0;
                        r_idx   <= w_idx_next;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    // Addresses at or above NDIG match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                r_shadow[i] <= 4'h0;
                r_active[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_wr_fire && (wr.wr_addr == 3'(i))) begin
                    r_shadow[i] <= wr.wr_data;
                end
                if (w_copy) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_copy) begin
                r_pending <= 1'b0;
            end else if (wr.commit) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl against a frame-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_ndig   = 4;
    localparam int c_div    = 4;
    localparam int c_guard  = 1;
    localparam int c_slot   = c_div + c_guard;
    localparam int c_period = c_ndig * c_slot;

    localparam logic [6:0] c_dec [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [c_ndig-1:0] mask;
    logic [6:0]        seg;
    logic [c_ndig-1:0] an;
    logic              frame_done;

    seg_scan_ctrl_if wr_if ();

    seg_scan_ctrl #(.NDIG(c_ndig), .DIV(c_div), .GUARD(c_guard)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mask       (mask),
        .wr         (wr_if.slave),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: scan position is just elapsed cycles since leaving OFF.
    bit          m_on;
    int          m_t;
    bit          m_pend;
    logic [3:0]  m_sh  [c_ndig];
    logic [3:0]  m_act [c_ndig];
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd;
    int          fd_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_t = 0; m_pend = 0;
        for (int i = 0; i < c_ndig; i++) begin
            m_sh[i] = 4'h0; m_act[i] = 4'h0;
        end
        e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0;
    endtask

    task automatic model_edge();
        int  pos, dig;
        bit  drv, wrap, fire, copy;
        if (!rst_n) return;
        pos  = m_t % c_period;
        dig  = pos / c_slot;
        drv  = (pos % c_slot) < c_div;
        wrap = m_on && en && (pos == c_period - 1);
        fire = wr_if.wr_valid && !m_pend && (wr_if.wr_addr < c_ndig);
        copy = m_pend && (!m_on || wrap);
        if (en && m_on && drv && mask[dig]) begin
            e_seg = c_dec[m_act[dig]];
            e_an  = ~(4'b0001 << dig);
        end else begin
            e_seg = 7'h7F;
            e_an  = 4'hF;
        end
        e_fd = wrap;
        if (copy) m_act = m_sh;
        if (fire) m_sh[wr_if.wr_addr] = wr_if.wr_data;
        if (copy) m_pend = 0;
        else if (wr_if.commit) m_pend = 1;
        if (!en) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("an", 32'(an), 32'(e_an));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
        check_eq("wr_ready", 32'(wr_if.wr_ready), 32'(!m_pend));
        if (frame_done) fd_q.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d, input bit with_commit);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        wr_if.commit   = with_commit;
        step();
        wr_if.wr_valid = 1'b0;
        wr_if.commit   = 1'b0;
    endtask

    task automatic check_periods(input string tag);
        for (int i = 1; i < fd_q.size(); i++)
            check_eq(tag, 32'(fd_q[i] - fd_q[i-1]), 32'(c_period));
        fd_q.delete();
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; en = 1'b0; mask = 4'hF;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = 3'd0; wr_if.wr_data = 4'h0; wr_if.commit = 1'b0;
        model_reset();
        run(3);
        rst_n = 1'b1;

        // Blank digits all read 0 -> seg 01, frame period checked.
        en = 1'b1;
        run(65);
        check_eq("fd_count_a", 32'(fd_q.size() >= 2), 32'd1);
        check_periods("frame_period_a");

        // Mid-frame commit of 1,A,C,F.
        run(7);
        do_write(3'd0, 4'h1, 1'b0);
        do_write(3'd1, 4'hA, 1'b0);
        do_write(3'd2, 4'hC, 1'b0);
        do_write(3'd3, 4'hF, 1'b1);
        run(50);

        // Commit landing exactly on the wrap cycle is deferred one frame.
        do_write(3'd0, 4'h5, 1'b0);
        do_write(3'd2, 4'h8, 1'b0);
        found = 0;
        for (int k = 0; k < 2 * c_period && !found; k++) begin
            if (m_on && (m_t % c_period) == c_period - 1) found = 1;
            else step();
        end
        check_eq("wrap_found", 32'(found), 32'd1);
        wr_if.commit = 1'b1;
        step();
        wr_if.commit = 1'b0;
        run(45);

        // Masked digits: 1 and 3 stay dark, period unchanged.
        fd_q.delete();
        mask = 4'b0101;
        run(62);
        check_periods("frame_period_mask");
        mask = 4'hF;

        // Drop enable during digit 2 drive.
        found = 0;
        for (int k = 0; k < 2 * c_period && !found; k++) begin
            if (m_on && (m_t % c_period) >= 2 * c_slot && (m_t % c_period) < 2 * c_slot + c_div - 1) found = 1;
            else step();
        end
        check_eq("digit2_found", 32'(found), 32'd1);
        en = 1'b0;
        step();
        check_eq("en_drop_an", 32'(an), 32'hF);
        check_eq("en_drop_seg", 32'(seg), 32'h7F);
        en = 1'b1;
        run(30);

        // Out-of-range write, then asynchronous reset mid-drive.
        do_write(3'd5, 4'h7, 1'b0);
        found = 0;
        for (int k = 0; k < 2 * c_period && !found; k++) begin
            if (e_an != 4'hF) found = 1;
            else step();
        end
        check_eq("lit_found", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_seg", 32'(seg), 32'h7F);
        check_eq("async_an", 32'(an), 32'hF);
        check_eq("async_fd", 32'(frame_done), 32'd0);
        check_eq("async_ready", 32'(wr_if.wr_ready), 32'd1);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(25);

        // Randomised traffic against the model.
        for (int i = 0; i < 700; i++) begin
            en             = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            wr_if.wr_valid = $urandom_range(0, 1) == 1;
            wr_if.wr_addr  = 3'($urandom_range(0, 7));
            wr_if.wr_data  = 4'($urandom_range(0, 15));
            wr_if.commit   = ($urandom_range(0, 19) == 0);
            step();
        end
        wr_if.wr_valid = 1'b0;
        wr_if.commit   = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 8, number of multiplexed digits; legal values are 2 to 8, and the index width is 3 bits.
REQ-002 Parameter DIV, default 50000, clock cycles each digit is driven; legal values are 2 or more.
REQ-003 Parameter GUARD, default 2, blanking cycles between digits; legal values are 0 or more.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  1 = scan the display, 0 = display off.
- mask  input  NDIG  per-digit enable; 1 = lit.
- wr_valid  input  1  shadow-write request.
- wr_ready  output  1  shadow-write accept.
- wr_addr  input  3  digit index to write.
- wr_data  input  4  hex nibble to write.
- commit  input  1  single-cycle pulse that requests a shadow-to-active copy.
- seg  output  7  active-low segments; bit6 = a through bit0 = g.
- an  output  NDIG  active-low digit selects.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-005 The block SHALL hold NDIG 4-bit shadow registers and NDIG 4-bit active registers.
REQ-006 A write SHALL be accepted when wr_valid and wr_ready are both 1, and SHALL load shadow[wr_addr] with wr_data.
REQ-007 A write SHALL be ignored when wr_addr is NDIG or greater.
REQ-008 wr_ready SHALL equal the inverse of commit_pending.
REQ-009 A write accepted in the same cycle as a commit pulse SHALL be included in that commit.
REQ-010 The block SHALL be a state machine with states OFF, DRIVE and GUARD, a cycle counter div_cnt, and a digit index idx.
REQ-011 In OFF, an SHALL be all 1s and seg SHALL be 7'h7F; when en=1, the next state SHALL be DRIVE with idx=0 and div_cnt=0.
REQ-012 In DRIVE, an[idx] SHALL be 0 when mask[idx]=1, and seg SHALL be decode(active[idx]); all other an bits SHALL be 1.
REQ-013 In DRIVE with mask[idx]=0, an SHALL be all 1s and seg SHALL be 7'h7F; the slot timing SHALL be unchanged.
REQ-014 The decode SHALL be, in hex: 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F, 8:00, 9:04, A:08, B:60, C:31, D:42, E:30, F:38.
REQ-015 DRIVE SHALL last exactly DIV cycles and then enter GUARD; if GUARD=0, it SHALL advance idx directly.
REQ-016 GUARD SHALL last exactly GUARD cycles, with an all 1s and seg 7'h7F, and then return to DRIVE with idx+1 and div_cnt=0.
REQ-017 On the transition from idx=NDIG-1 to idx=0 (the wrap cycle), frame_done SHALL be 1 for exactly one cycle.
REQ-018 If commit_pending=1 on the wrap cycle, all shadow registers SHALL be copied to the active registers and commit_pending SHALL clear; this is the only copy point while scanning.
REQ-019 A commit pulse while commit_pending=0 SHALL set commit_pending on the next edge.
REQ-020 A commit pulse arriving on a wrap cycle SHALL be deferred to the following wrap.
REQ-021 A commit pulse while commit_pending=1 SHALL have no additional effect.
REQ-022 While in OFF, a pending commit SHALL copy shadow to active on the next cycle and clear commit_pending.
REQ-023 Deasserting en in any state SHALL enter OFF on the next edge, blank the outputs on that edge, reset idx and div_cnt to 0, and leave commit_pending unchanged apart from REQ-022.
REQ-024 Changes to mask SHALL take effect combinationally on the current digit slot.
REQ-025 seg, an and frame_done SHALL be driven from registers, one cycle after the state and idx that produce them.
REQ-026 The number of cycles from one frame_done pulse to the next SHALL be NDIG*(DIV+GUARD).

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously set state=OFF, idx=0, div_cnt=0 and commit_pending=0.
REQ-028 When rst_n=0, all shadow and active registers SHALL be set to 0.
REQ-029 When rst_n=0, the outputs SHALL be seg=7'h7F, an all 1s, frame_done=0 and wr_ready=1.
REQ-030 Reset release SHALL be synchronous to clk; the first state transition SHALL occur on the first edge after rst_n rises.
REQ-031 Reset asserted during DRIVE SHALL blank the outputs immediately, with no clock edge required.

Verification (NDIG=4, DIV=4, GUARD=1)
REQ-032 Reset, en=1, mask=4'hF, no writes -> each digit in turn has its an bit at 0 for 4 cycles with seg=7'h01, separated by 1 all-blank cycle; frame_done is 1 every 20 cycles.
REQ-033 Write digits 0 to 3 with 1, A, C, F, then commit mid-frame -> the current frame is unchanged; the next frame shows 4F, 08, 31, 38; wr_ready is 0 from the cycle after commit until the cycle after the wrap.
REQ-034 Commit on the exact wrap cycle -> no copy at that wrap; the copy occurs one frame later.
REQ-035 mask=4'b0101 -> an[1] and an[3] are never 0; the frame period stays 20 cycles.
REQ-036 en dropped during digit 2 DRIVE -> the next edge gives an=4'hF and seg=7'h7F; with en=1 again, the scan restarts at digit 0 after 1 OFF cycle.
REQ-037 rst_n pulsed low mid-DRIVE, plus a wr_addr=5 write -> the outputs blank asynchronously; after reset the display shows 01 on all digits, and the out-of-range write changes no register.
